branch_resolve_queue: RTL

//  In-order queue of predicted branches, placed between fetch (which consumes the 2-bit-counter

---
 rtl/branch_resolve_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches awaiting resolution in EX; raises flush/redirect on a
// mispredict and a training pulse per resolve. Optional counters enabled by `define BRQ_STATS_EN.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic [XLEN-1:0]          push_pc,
  input  logic                     push_taken,
  input  logic [XLEN-1:0]          push_target,
  output logic                     push_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [XLEN-1:0]          res_target,
  output logic                     flush,
  output logic [XLEN-1:0]          redirect_pc,
  output logic                     train_valid,
  output logic                     train_taken,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0]              stat_branches,
  output logic [15:0]              stat_mispredicts
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  entry_t          head;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_res;
  logic            mispredict;
  logic            squash;
  logic [XLEN-1:0] correct_pc;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned
  // and infer a latch.
  always_comb begin
    head       = mem[rd_ptr];
    full       = (count == FULL_COUNT);
    empty      = (count == '0);
    push_ready = !full;
    do_push    = push_valid && !full;
    do_res     = res_valid && !empty;
    mispredict = 1'b0;
    correct_pc = head.pc + XLEN'(4);
    if (do_res) begin
      mispredict = (res_taken != head.taken) ||
                   (res_taken && (res_target != head.target));
    end
    if (res_taken) begin
      correct_pc = res_target;
    end
    squash = do_res && mispredict;
  end

  // NOTE: the entry storage has no reset; pointers and count alone decide what is live, so
  // stale contents are never observed and the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (do_push && !squash) begin
      mem[wr_ptr] <= '{pc: push_pc, taken: push_taken, target: push_target};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (squash) begin
      // Everything younger than the mispredicted branch is wrong-path, including any push now.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_res) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_res})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      train_valid <= 1'b0;
      train_taken <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      flush       <= squash;
      train_valid <= do_res;
      if (squash) begin
        redirect_pc <= correct_pc;
      end
      if (do_res) begin
        train_taken <= res_taken;
      end
      if (res_valid && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (do_res && (stat_branches != 16'hFFFF)) begin
        stat_branches <= stat_branches + 16'd1;
      end
      if (squash && (stat_mispredicts != 16'hFFFF)) begin
        stat_mispredicts <= stat_mispredicts + 16'd1;
      end
    end
  end
`endif

endmodule
